// File: rtl/p4_router_page_free_list.sv
// Free-page allocator: circular list of unused queue-memory page indices, swept
// full after reset, handing pages out on an AXIS-style alloc port and taking them back on free.
module p4_router_page_free_list #(
  parameter int NUM_PAGES     = 1024,
  parameter int NUM_PAGES_LOG = $clog2(NUM_PAGES)
) (
  input  logic                     clk,
  input  logic                     aresetn,
  output logic                     init_done,
  output logic                     alloc_tvalid,
  input  logic                     alloc_tready,
  output logic [NUM_PAGES_LOG-1:0] alloc_tdata,
  input  logic                     free_tvalid,
  output logic                     free_tready,
  input  logic [NUM_PAGES_LOG-1:0] free_tdata,
  output logic [NUM_PAGES_LOG:0]   free_count,
  output logic                     overflow_err
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [NUM_PAGES_LOG:0]   FULL_CNT  = (NUM_PAGES_LOG+1)'(NUM_PAGES);
  localparam logic [NUM_PAGES_LOG-1:0] LAST_PAGE = NUM_PAGES_LOG'(NUM_PAGES-1);

  logic [0:0]               state;
  logic [NUM_PAGES_LOG-1:0] wr_ptr, rd_ptr, sweep_cnt;
  logic                     ram_full, rd_pending;
  logic [NUM_PAGES_LOG-1:0] mem [NUM_PAGES];
  logic [NUM_PAGES_LOG-1:0] ram_q;
  logic [NUM_PAGES_LOG-1:0] wr_data;
  logic                     run, free_hs, free_acc, alloc_hs, slot_free;
  logic                     ram_empty, rd_en, wr_en;

  assign run         = (state == ST_RUN);
  assign free_tready = run;
  assign free_hs     = free_tvalid && run;
  assign free_acc    = free_hs && (free_count != FULL_CNT);
  assign alloc_hs    = alloc_tvalid && alloc_tready;
  // Output slot can take new data at this edge: empty, or being drained now.
  assign slot_free   = !alloc_tvalid || alloc_tready;
  assign ram_empty   = (wr_ptr == rd_ptr) && !ram_full;
  assign rd_en       = run && slot_free && !ram_empty;
  assign wr_en       = run ? free_acc : 1'b1;
  assign wr_data     = run ? free_tdata : sweep_cnt;

  // Simple-dual-port storage; read data held in ram_q until the slot frees.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
    if (rd_en) ram_q <= mem[rd_ptr];
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= ST_INIT;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      sweep_cnt    <= '0;
      ram_full     <= 1'b0;
      rd_pending   <= 1'b0;
      alloc_tvalid <= 1'b0;
      alloc_tdata  <= '0;
      free_count   <= '0;
      overflow_err <= 1'b0;
      init_done    <= 1'b0;
    end else begin
      overflow_err <= free_hs && !free_acc;
      if (!run) begin
        wr_ptr     <= wr_ptr + 1'b1;
        sweep_cnt  <= sweep_cnt + 1'b1;
        free_count <= free_count + 1'b1;
        if (sweep_cnt == LAST_PAGE) begin
          state     <= ST_RUN;
          init_done <= 1'b1;
          ram_full  <= 1'b1;
        end
      end else begin
        if (free_acc) wr_ptr <= wr_ptr + 1'b1;
        if (rd_en)    rd_ptr <= rd_ptr + 1'b1;
        // Equal pointers are ambiguous; track full on a net write or net read.
        if (free_acc && !rd_en)
          ram_full <= (NUM_PAGES_LOG'(wr_ptr + 1'b1) == rd_ptr);
        else if (rd_en && !free_acc)
          ram_full <= 1'b0;
        rd_pending <= rd_en || (rd_pending && !slot_free);
        if (rd_pending && slot_free) begin
          alloc_tvalid <= 1'b1;
          alloc_tdata  <= ram_q;
        end else if (alloc_hs) begin
          alloc_tvalid <= 1'b0;
        end
        case ({free_acc, alloc_hs})
          2'b10:   free_count <= free_count + 1'b1;
          2'b01:   free_count <= free_count - 1'b1;
          default: free_count <= free_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_p4_router_page_free_list.sv
// Scoreboard bench for the page free list: stimulus pushes expected pages into a
// FIFO model, a negedge monitor pops and compares on every alloc handshake.
module tb_p4_router_page_free_list;
  localparam int NP = 8;
  localparam int LG = 3;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          init_done, alloc_tvalid, alloc_tready, free_tvalid, free_tready, overflow_err;
  logic [LG-1:0] alloc_tdata, free_tdata;
  logic [LG:0]   free_count;

  p4_router_page_free_list #(.NUM_PAGES(NP)) dut (
    .clk(clk), .aresetn(aresetn), .init_done(init_done),
    .alloc_tvalid(alloc_tvalid), .alloc_tready(alloc_tready), .alloc_tdata(alloc_tdata),
    .free_tvalid(free_tvalid), .free_tready(free_tready), .free_tdata(free_tdata),
    .free_count(free_count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int q[$];     // expected allocation order (model of pages owned by the DUT)
  int pool[$];  // pages currently held by the bench
  bit prev_stall = 1'b0;
  int prev_data  = 0;
  int mon_exp;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!aresetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", int'(alloc_tvalid), 1);
        chk("stall_data_held", int'(alloc_tdata), prev_data);
      end
      if (alloc_tvalid && alloc_tready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL alloc_unexpected: got page %0d, expected no allocation", alloc_tdata);
        end else begin
          mon_exp = q.pop_front();
          chk("alloc_data", int'(alloc_tdata), mon_exp);
          pool.push_back(mon_exp);
        end
      end
      prev_stall = alloc_tvalid && !alloc_tready;
      prev_data  = int'(alloc_tdata);
    end
  end

  task automatic do_free(input int p);
    free_tvalid = 1'b1;
    free_tdata  = LG'(p);
    @(posedge clk);
    if (q.size() < NP) q.push_back(p);
    #1 free_tvalid = 1'b0;
  endtask

  task automatic take_free(input int p);
    for (int i = 0; i < pool.size(); i++)
      if (pool[i] == p) begin
        pool.delete(i);
        break;
      end
    do_free(p);
  endtask

  task automatic wait_empty(input string name, input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (free_count == 0 && !alloc_tvalid) begin
        done = 1'b1;
        break;
      end
    end
    chk(name, int'(done), 1);
  endtask

  task automatic init_seq();
    @(posedge clk);
    #1 aresetn = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("init_done_early", int'(init_done), 0);
    chk("init_count_7", int'(free_count), 7);
    @(negedge clk);
    chk("init_done_rise", int'(init_done), 1);
    chk("init_count_full", int'(free_count), NP);
    chk("free_tready_run", int'(free_tready), 1);
    @(negedge clk);
    chk("first_valid_lat1", int'(alloc_tvalid), 0);
    @(negedge clk);
    chk("first_valid_lat2", int'(alloc_tvalid), 1);
    chk("first_data", int'(alloc_tdata), 0);
    for (int i = 0; i < NP; i++) q.push_back(i);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    alloc_tready = 1'b0;
    free_tvalid  = 1'b0;
    free_tdata   = '0;
    repeat (2) @(negedge clk);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_alloc_tvalid", int'(alloc_tvalid), 0);
    chk("rst_alloc_tdata", int'(alloc_tdata), 0);
    chk("rst_free_tready", int'(free_tready), 0);
    chk("rst_free_count", int'(free_count), 0);
    chk("rst_overflow", int'(overflow_err), 0);

    init_seq();
    repeat (3) @(negedge clk);
    chk("stalled_valid", int'(alloc_tvalid), 1);
    chk("stalled_count", int'(free_count), NP);

    // Drain at full rate: exactly NP handshakes on NP consecutive edges.
    @(posedge clk);
    #1 alloc_tready = 1'b1;
    repeat (NP) @(posedge clk);
    @(negedge clk);
    chk("drain_valid", int'(alloc_tvalid), 0);
    chk("drain_count", int'(free_count), 0);
    chk("drain_model_left", q.size(), 0);

    // Empty refill: page visible two edges after the free handshake.
    take_free(5);
    @(negedge clk);
    chk("refill_count_1", int'(free_count), 1);
    chk("refill_valid_e0", int'(alloc_tvalid), 0);
    @(negedge clk);
    chk("refill_valid_e1", int'(alloc_tvalid), 0);
    @(negedge clk);
    chk("refill_valid_e2", int'(alloc_tvalid), 1);
    chk("refill_data", int'(alloc_tdata), 5);
    @(negedge clk);
    chk("refill_count_0", int'(free_count), 0);
    chk("refill_valid_gone", int'(alloc_tvalid), 0);

    // Simultaneous alloc + free with three pages queued.
    alloc_tready = 1'b0;
    take_free(1);
    take_free(3);
    take_free(4);
    repeat (3) @(negedge clk);
    chk("simul_pre_count", int'(free_count), 3);
    chk("simul_pre_valid", int'(alloc_tvalid), 1);
    alloc_tready = 1'b1;
    take_free(2);
    alloc_tready = 1'b0;
    @(negedge clk);
    chk("simul_count", int'(free_count), 3);
    alloc_tready = 1'b1;
    wait_empty("simul_drain", 20);

    // Backpressure with frees drawn from the bench-held pool.
    for (int c = 0; c < 60; c++) begin
      alloc_tready = (c % 3 != 0);
      if ($urandom_range(0, 1) == 1 && pool.size() > 0) do_free(pool.pop_front());
      else begin
        @(posedge clk);
        #1;
      end
    end
    alloc_tready = 1'b1;
    wait_empty("bp_drain", 40);
    pool.sort();
    chk("bp_pool_size", pool.size(), NP);
    for (int i = 0; i < NP && i < pool.size(); i++) chk("bp_pool_page", pool[i], i);

    // Overflow: refill completely, then one more free is dropped.
    alloc_tready = 1'b0;
    while (pool.size() > 0) do_free(pool.pop_front());
    repeat (3) @(negedge clk);
    chk("ovf_pre_count", int'(free_count), NP);
    chk("ovf_pre_err", int'(overflow_err), 0);
    do_free(1);
    @(negedge clk);
    chk("ovf_pulse", int'(overflow_err), 1);
    chk("ovf_count", int'(free_count), NP);
    @(negedge clk);
    chk("ovf_pulse_end", int'(overflow_err), 0);
    chk("ovf_count_hold", int'(free_count), NP);

    // Asynchronous reset mid-cycle with a page presented.
    @(posedge clk);
    #3 aresetn = 1'b0;
    #1;
    chk("arst_valid", int'(alloc_tvalid), 0);
    chk("arst_init_done", int'(init_done), 0);
    chk("arst_count", int'(free_count), 0);
    chk("arst_free_tready", int'(free_tready), 0);
    q.delete();
    pool.delete();
    repeat (3) @(posedge clk);
    init_seq();
    @(posedge clk);
    #1 alloc_tready = 1'b1;
    wait_empty("reinit_drain", 20);
    chk("reinit_pool_size", pool.size(), NP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/p4_router_page_free_list.md
Name: p4_router_page_free_list

Overview:
- Free-page allocator for the P4 router queue memory.
- Holds the indices of all unused queue-memory pages in a circular list.
- Hands pages to the congestion manager/enqueue path for `current_page_ptr`/`next_page_ptr` assignment.
- Takes back pages released by the queue memory dequeue stage on its `queue_mem_free` stream.

Parameters:
- NUM_PAGES, 1024: number of queue-memory pages. Must be a power of two and at least 4.
- NUM_PAGES_LOG, $clog2(NUM_PAGES): page index width. Derived; do not override.

Ports:
- clk  input  1  core clock.
- aresetn  input  1  asynchronous active-low reset.
- init_done  output  1  high once the initial page sweep completes.
- alloc_tvalid  output  1  a free page index is presented.
- alloc_tready  input  1  consumer takes the presented page.
- alloc_tdata  output  NUM_PAGES_LOG  allocated page index.
- free_tvalid  input  1  a page is being returned.
- free_tready  output  1  accepting returned pages.
- free_tdata  input  NUM_PAGES_LOG  returned page index.
- free_count  output  NUM_PAGES_LOG+1  pages currently owned by this block (RAM + in-flight read + output register).
- overflow_err  output  1  one-cycle pulse: free arrived while free_count == NUM_PAGES; page dropped.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (aresetn); all flops clear on its assertion. Storage RAM contents are not reset.
- Reset values: init_done=0, alloc_tvalid=0, alloc_tdata=0, free_tready=0, free_count=0, overflow_err=0. wr_ptr, rd_ptr, state=INIT, sweep counter=0.
- Storage: simple-dual-port block RAM, NUM_PAGES x NUM_PAGES_LOG, synchronous read with 1-cycle latency.
- wr_ptr and rd_ptr are NUM_PAGES_LOG wide and wrap naturally modulo NUM_PAGES.
- State INIT:
  - Writes RAM[i]=i for i=0..NUM_PAGES-1, one per cycle. wr_ptr advances and free_count increments each cycle.
  - free_tready=0 and alloc_tvalid=0 throughout.
  - After writing entry NUM_PAGES-1: wr_ptr has wrapped to 0, free_count=NUM_PAGES, state -> RUN, init_done=1 on the next cycle.
  - INIT takes exactly NUM_PAGES cycles after reset release.
- State RUN:
  - free_tready=1 permanently.
  - Free handshake, free_count < NUM_PAGES: write RAM[wr_ptr]=free_tdata, wr_ptr+1.
  - Free handshake, free_count == NUM_PAGES: no write, pointers unchanged, overflow_err pulses 1 cycle later.
  - Output stage is a single register plus a read-in-flight flag.
  - A RAM read issues when (output register empty OR alloc handshake this cycle) AND no read is in flight-or-loading into an occupied slot AND ram_entries > 0. ram_entries = wr_ptr - rd_ptr, with full flag to distinguish wrap. An issued read advances rd_ptr.
  - Read data loads alloc_tdata and sets alloc_tvalid the following edge.
  - Sustained throughput is 1 allocation per cycle while ram_entries > 0.
- AXIS rules: alloc_tdata is held stable while alloc_tvalid=1 and alloc_tready=0. alloc_tvalid never depends combinationally on alloc_tready.
- Latency: a free into a completely empty list (free_count=0) gives alloc_tvalid=1 exactly 2 edges after the free handshake edge. No bypass path.
- free_count arithmetic:
  - +1 on an accepted (non-overflow) free; -1 on an alloc handshake; unchanged when both occur in the same cycle.
  - Never exceeds NUM_PAGES; never wraps below 0.
  - With free_count=0 and no free, alloc_tvalid stays 0.
- Simultaneous events:
  - Alloc and free in the same cycle are both serviced.
  - A read and a write to the same RAM address in one cycle cannot occur, since ram_entries > 0 is required to read.
- Reset mid-operation:
  - Everything returns to reset values immediately.
  - Any presented page is withdrawn: alloc_tvalid drops asynchronously.
  - INIT restarts on release. Pages held downstream are considered reclaimed.
- Page uniqueness (no double-free) is not checked beyond the overflow case.

Test Plan:
- Init (NUM_PAGES=8): release reset, alloc_tready=0 -> init_done rises after 8 cycles; alloc_tvalid=1 with alloc_tdata=0 two cycles later; free_count=8.
- Drain: alloc_tready=1 continuously after init -> alloc_tdata = 0,1,...,7 on consecutive cycles; alloc_tvalid=0 afterwards; free_count=0.
- Empty refill: after drain, free page 5 -> alloc_tvalid=1, alloc_tdata=5 exactly 2 edges later; free_count steps 0->1->0 on accept.
- Backpressure: alloc_tready toggled 1/0 with random frees -> no index lost or duplicated; tdata stable while stalled; final set of allocated+held indices = {0..7}.
- Simultaneous: with free_count=3, alloc and free of page 2 in the same cycle -> free_count stays 3; page 2 emitted after the other queued entries (FIFO order).
- Overflow and async reset: free page 1 while free_count=8 -> overflow_err single pulse, free_count stays 8. Then assert aresetn low mid-stream -> alloc_tvalid, init_done, free_count all 0 immediately; init repeats on release.
